// File: rtl/etroc2_event_checker.sv
// ETROC2 event checker: forwards non-filler frames to the readout FIFO, checks event structure,
// hit counts, L1 continuity and overflow, and keeps saturating statistics for slow control.
module etroc2_event_checker #(
  parameter int unsigned MAX_HITS = 208,
  parameter bit          CHECK_L1 = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk40,
  input  logic             reset,
  input  logic             enable,
  input  logic             clrCounters,
  input  logic             aligned,
  input  logic             dataValid,
  input  logic [1:0]       dataType,
  input  logic             dataError,
  input  logic [39:0]      din,
  input  logic             fifoFull,
  output logic [39:0]      dout,
  output logic [1:0]       doutType,
  output logic             doutWrEn,
  output logic             eventDone,
  output logic             eventGood,
  output logic [2:0]       errorCode,
  output logic [7:0]       l1Counter,
  output logic [CNT_W-1:0] eventCount,
  output logic [CNT_W-1:0] badEventCount,
  output logic [CNT_W-1:0] dropCount
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StEvent = 2'd1;
  localparam logic [1:0] StDrop  = 2'd2;

  localparam logic [1:0] TypeHeader  = 2'b01;
  localparam logic [1:0] TypeData    = 2'b10;
  localparam logic [1:0] TypeTrailer = 2'b11;

  localparam logic [7:0] MaxHitsB = MAX_HITS[7:0];

  localparam logic [2:0] ErrOutside  = 3'd1;
  localparam logic [2:0] ErrNoTrl    = 3'd2;
  localparam logic [2:0] ErrHitCnt   = 3'd3;
  localparam logic [2:0] ErrL1       = 3'd4;
  localparam logic [2:0] ErrTooMany  = 3'd5;
  localparam logic [2:0] ErrOverflow = 3'd6;
  localparam logic [2:0] ErrLink     = 3'd7;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       hit_cnt_q, hit_cnt_d;
  logic             ev_bad_q, ev_bad_d;
  logic [7:0]       l1_q, l1_d;
  logic             l1_vld_q, l1_vld_d;
  logic [39:0]      dout_q, dout_d;
  logic [1:0]       dout_type_q, dout_type_d;
  logic             wr_en_q, wr_en_d;
  logic             done_q, done_d;
  logic             good_q, good_d;
  logic [2:0]       err_q, err_d;
  logic [CNT_W-1:0] ev_cnt_q, ev_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic       accept;
  logic       in_event;
  logic       link_fault;
  logic       hdr_start;
  logic       close_ev;
  logic       close_good;
  logic       drop_inc;
  logic [2:0] err_new;
  logic [7:0] l1_next;
  logic [7:0] din_l1;
  logic [7:0] din_hits;

  assign accept     = enable & aligned & dataValid & (dataType != 2'b00);
  assign in_event   = (state_q == StEvent) || (state_q == StDrop);
  assign link_fault = in_event & (~aligned | dataError);
  assign l1_next    = l1_q + 8'd1;
  assign din_l1     = din[29:22];
  assign din_hits   = din[15:8];

  always_comb begin
    state_d     = state_q;
    hit_cnt_d   = hit_cnt_q;
    ev_bad_d    = ev_bad_q;
    l1_d        = l1_q;
    l1_vld_d    = l1_vld_q;
    dout_d      = dout_q;
    dout_type_d = dout_type_q;
    wr_en_d     = 1'b0;
    hdr_start   = 1'b0;
    close_ev    = 1'b0;
    close_good  = 1'b0;
    drop_inc    = 1'b0;
    err_new     = 3'd0;

    if (!enable) begin
      // Abort any open event without reporting it.
      state_d = StIdle;
    end else begin
      if (accept) begin
        if (!fifoFull) begin
          wr_en_d     = 1'b1;
          dout_d      = din;
          dout_type_d = dataType;
        end else begin
          drop_inc = 1'b1;
        end
      end

      if (link_fault) begin
        close_ev = 1'b1;
        err_new  = ErrLink;
        state_d  = StIdle;
        l1_vld_d = 1'b0;
      end else if (accept) begin
        unique case (state_q)
          StIdle: begin
            if (dataType == TypeHeader) hdr_start = 1'b1;
            else                        err_new   = ErrOutside;
          end
          StEvent: begin
            unique case (dataType)
              TypeData: begin
                if (hit_cnt_q == MaxHitsB) begin
                  err_new  = ErrTooMany;
                  ev_bad_d = 1'b1;
                  state_d  = StDrop;
                end else begin
                  hit_cnt_d = hit_cnt_q + 8'd1;
                end
                if (fifoFull) begin
                  if (err_new == 3'd0) err_new = ErrOverflow;
                  ev_bad_d = 1'b1;
                end
              end
              TypeTrailer: begin
                close_ev = 1'b1;
                state_d  = StIdle;
                if (din_hits != hit_cnt_q) err_new = ErrHitCnt;
                else if (fifoFull)         err_new = ErrOverflow;
                close_good = ~ev_bad_q & (din_hits == hit_cnt_q) & ~fifoFull;
              end
              TypeHeader: begin
                close_ev  = 1'b1;
                err_new   = ErrNoTrl;
                hdr_start = 1'b1;
              end
              default: ;
            endcase
          end
          StDrop: begin
            // Structure checks are suspended until the event is closed.
            unique case (dataType)
              TypeTrailer: begin
                close_ev = 1'b1;
                state_d  = StIdle;
                if (fifoFull) err_new = ErrOverflow;
              end
              TypeHeader: begin
                close_ev  = 1'b1;
                hdr_start = 1'b1;
              end
              TypeData: begin
                if (fifoFull) err_new = ErrOverflow;
              end
              default: ;
            endcase
          end
          default: state_d = StIdle;
        endcase
      end

      if (hdr_start) begin
        state_d   = StEvent;
        hit_cnt_d = 8'd0;
        ev_bad_d  = 1'b0;
        l1_d      = din_l1;
        l1_vld_d  = 1'b1;
        if (CHECK_L1 && l1_vld_q && (din_l1 != l1_next)) begin
          if (err_new == 3'd0) err_new = ErrL1;
          ev_bad_d = 1'b1;
        end
        if (fifoFull) begin
          if (err_new == 3'd0) err_new = ErrOverflow;
          ev_bad_d = 1'b1;
        end
      end
    end

    done_d = close_ev;
    good_d = close_good;

    if (clrCounters) begin
      err_d      = 3'd0;
      ev_cnt_d   = '0;
      bad_cnt_d  = '0;
      drop_cnt_d = '0;
    end else begin
      err_d      = (err_q == 3'd0) ? err_new : err_q;
      ev_cnt_d   = close_ev ? sat_inc(ev_cnt_q) : ev_cnt_q;
      bad_cnt_d  = (close_ev && !close_good) ? sat_inc(bad_cnt_q) : bad_cnt_q;
      drop_cnt_d = drop_inc ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end
  end

  always_ff @(posedge clk40) begin
    if (!reset) begin
      state_q     <= StIdle;
      hit_cnt_q   <= 8'd0;
      ev_bad_q    <= 1'b0;
      l1_q        <= 8'd0;
      l1_vld_q    <= 1'b0;
      dout_q      <= 40'd0;
      dout_type_q <= 2'd0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      good_q      <= 1'b0;
      err_q       <= 3'd0;
      ev_cnt_q    <= '0;
      bad_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hit_cnt_q   <= hit_cnt_d;
      ev_bad_q    <= ev_bad_d;
      l1_q        <= l1_d;
      l1_vld_q    <= l1_vld_d;
      dout_q      <= dout_d;
      dout_type_q <= dout_type_d;
      wr_en_q     <= wr_en_d;
      done_q      <= done_d;
      good_q      <= good_d;
      err_q       <= err_d;
      ev_cnt_q    <= ev_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign dout          = dout_q;
  assign doutType      = dout_type_q;
  assign doutWrEn      = wr_en_q;
  assign eventDone     = done_q;
  assign eventGood     = good_q;
  assign errorCode     = err_q;
  assign l1Counter     = l1_q;
  assign eventCount    = ev_cnt_q;
  assign badEventCount = bad_cnt_q;
  assign dropCount     = drop_cnt_q;

endmodule

// File: tb/tb_etroc2_event_checker.sv
// Directed self-checking bench for etroc2_event_checker.
module tb_etroc2_event_checker;

  localparam int unsigned CntW = 16;

  logic            clk40 = 1'b0;
  logic            reset;
  logic            enable;
  logic            clrCounters;
  logic            aligned;
  logic            dataValid;
  logic [1:0]      dataType;
  logic            dataError;
  logic [39:0]     din;
  logic            fifoFull;
  logic [39:0]     dout;
  logic [1:0]      doutType;
  logic            doutWrEn;
  logic            eventDone;
  logic            eventGood;
  logic [2:0]      errorCode;
  logic [7:0]      l1Counter;
  logic [CntW-1:0] eventCount;
  logic [CntW-1:0] badEventCount;
  logic [CntW-1:0] dropCount;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;

  etroc2_event_checker #(
    .MAX_HITS(208),
    .CHECK_L1(1'b1),
    .CNT_W   (CntW)
  ) u_dut (
    .clk40        (clk40),
    .reset        (reset),
    .enable       (enable),
    .clrCounters  (clrCounters),
    .aligned      (aligned),
    .dataValid    (dataValid),
    .dataType     (dataType),
    .dataError    (dataError),
    .din          (din),
    .fifoFull     (fifoFull),
    .dout         (dout),
    .doutType     (doutType),
    .doutWrEn     (doutWrEn),
    .eventDone    (eventDone),
    .eventGood    (eventGood),
    .errorCode    (errorCode),
    .l1Counter    (l1Counter),
    .eventCount   (eventCount),
    .badEventCount(badEventCount),
    .dropCount    (dropCount)
  );

  always #12.5 clk40 = ~clk40;

  always @(negedge clk40) if (doutWrEn) wr_cnt++;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] hdr(input logic [7:0] l1);
    return {10'h0, l1, 22'h0};
  endfunction

  function automatic logic [39:0] trl(input logic [7:0] hits);
    return {24'h0, hits, 8'h0};
  endfunction

  function automatic logic [39:0] dat(input int unsigned i);
    return {8'hA5, i[31:0]};
  endfunction

  // One accepted frame; outputs are checked one cycle later, away from the edge.
  task automatic send(input logic [1:0] t, input logic [39:0] d, input logic full);
    dataValid = 1'b1;
    dataType  = t;
    din       = d;
    fifoFull  = full;
    @(posedge clk40);
    #1;
    dataValid = 1'b0;
    dataType  = 2'b00;
    fifoFull  = 1'b0;
    check("wren", {39'd0, doutWrEn}, {39'd0, ~full});
    if (!full) begin
      check("dout", dout, d);
      check("dtype", {38'd0, doutType}, {38'd0, t});
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk40);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge clk40);
    #1;
  endtask

  initial begin
    enable      = 1'b1;
    clrCounters = 1'b0;
    aligned     = 1'b1;
    dataValid   = 1'b0;
    dataType    = 2'b00;
    dataError   = 1'b0;
    din         = 40'd0;
    fifoFull    = 1'b0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk40);
    #1;
    check("rst_dout", dout, 40'd0);
    check("rst_wren", {39'd0, doutWrEn}, 40'd0);
    check("rst_done", {39'd0, eventDone}, 40'd0);
    check("rst_good", {39'd0, eventGood}, 40'd0);
    check("rst_err", {37'd0, errorCode}, 40'd0);
    check("rst_l1", {32'd0, l1Counter}, 40'd0);
    check("rst_evcnt", {24'd0, eventCount}, 40'd0);
    check("rst_badcnt", {24'd0, badEventCount}, 40'd0);
    check("rst_dropcnt", {24'd0, dropCount}, 40'd0);
    reset = 1'b1;

    // Three clean events, L1 = 5, 6, 7
    wr_cnt = 0;
    for (int e = 0; e < 3; e++) begin
      send(2'b01, hdr(8'(5 + e)), 1'b0);
      for (int i = 0; i < 4; i++) send(2'b10, dat(i), 1'b0);
      send(2'b11, trl(8'd4), 1'b0);
      check("t1_done", {39'd0, eventDone}, 40'd1);
      check("t1_good", {39'd0, eventGood}, 40'd1);
    end
    idle_cycle();
    check("t1_writes", 40'(wr_cnt), 40'd18);
    check("t1_evcnt", {24'd0, eventCount}, 40'd3);
    check("t1_badcnt", {24'd0, badEventCount}, 40'd0);
    check("t1_err", {37'd0, errorCode}, 40'd0);
    check("t1_l1", {32'd0, l1Counter}, 40'd7);

    // Trailer hit count mismatch
    send(2'b01, hdr(8'd8), 1'b0);
    for (int i = 0; i < 4; i++) send(2'b10, dat(i), 1'b0);
    send(2'b11, trl(8'd3), 1'b0);
    check("t2_done", {39'd0, eventDone}, 40'd1);
    check("t2_good", {39'd0, eventGood}, 40'd0);
    idle_cycle();
    check("t2_err", {37'd0, errorCode}, 40'd3);
    check("t2_badcnt", {24'd0, badEventCount}, 40'd1);
    check("t2_evcnt", {24'd0, eventCount}, 40'd4);

    // L1 wrap 255 -> 0 is fine, 0 -> 2 is a discontinuity
    do_reset();
    send(2'b01, hdr(8'd255), 1'b0);
    send(2'b11, trl(8'd0), 1'b0);
    send(2'b01, hdr(8'd0), 1'b0);
    send(2'b11, trl(8'd0), 1'b0);
    check("t3_wrap_good", {39'd0, eventGood}, 40'd1);
    check("t3_wrap_err", {37'd0, errorCode}, 40'd0);
    send(2'b01, hdr(8'd2), 1'b0);
    send(2'b11, trl(8'd0), 1'b0);
    check("t3_jump_good", {39'd0, eventGood}, 40'd0);
    check("t3_jump_err", {37'd0, errorCode}, 40'd4);
    check("t3_l1", {32'd0, l1Counter}, 40'd2);

    // Missing trailer: header inside an event
    do_reset();
    send(2'b01, hdr(8'd1), 1'b0);
    send(2'b10, dat(0), 1'b0);
    send(2'b10, dat(1), 1'b0);
    send(2'b01, hdr(8'd2), 1'b0);
    check("t4_done1", {39'd0, eventDone}, 40'd1);
    check("t4_good1", {39'd0, eventGood}, 40'd0);
    send(2'b11, trl(8'd0), 1'b0);
    check("t4_done2", {39'd0, eventDone}, 40'd1);
    check("t4_good2", {39'd0, eventGood}, 40'd1);
    idle_cycle();
    check("t4_err", {37'd0, errorCode}, 40'd2);
    check("t4_evcnt", {24'd0, eventCount}, 40'd2);
    check("t4_badcnt", {24'd0, badEventCount}, 40'd1);

    // FIFO full for two data frames
    do_reset();
    send(2'b01, hdr(8'd1), 1'b0);
    send(2'b10, dat(0), 1'b0);
    send(2'b10, dat(1), 1'b1);
    send(2'b10, dat(2), 1'b1);
    send(2'b10, dat(3), 1'b0);
    send(2'b11, trl(8'd4), 1'b0);
    check("t5_done", {39'd0, eventDone}, 40'd1);
    check("t5_good", {39'd0, eventGood}, 40'd0);
    idle_cycle();
    check("t5_drop", {24'd0, dropCount}, 40'd2);
    check("t5_err", {37'd0, errorCode}, 40'd6);
    check("t5_badcnt", {24'd0, badEventCount}, 40'd1);

    // Link fault mid-event, then clear
    do_reset();
    send(2'b01, hdr(8'd1), 1'b0);
    send(2'b10, dat(0), 1'b0);
    aligned = 1'b0;
    idle_cycle();
    aligned = 1'b1;
    check("t6_done", {39'd0, eventDone}, 40'd1);
    check("t6_good", {39'd0, eventGood}, 40'd0);
    check("t6_err", {37'd0, errorCode}, 40'd7);
    send(2'b11, trl(8'd0), 1'b0);
    check("t6_idle_nodone", {39'd0, eventDone}, 40'd0);
    check("t6_err_sticky", {37'd0, errorCode}, 40'd7);
    clrCounters = 1'b1;
    idle_cycle();
    clrCounters = 1'b0;
    check("t6_clr_evcnt", {24'd0, eventCount}, 40'd0);
    check("t6_clr_badcnt", {24'd0, badEventCount}, 40'd0);
    check("t6_clr_drop", {24'd0, dropCount}, 40'd0);
    check("t6_clr_err", {37'd0, errorCode}, 40'd0);

    // Clear wins over an increment in the same cycle
    send(2'b01, hdr(8'd9), 1'b0);
    clrCounters = 1'b1;
    send(2'b11, trl(8'd0), 1'b0);
    clrCounters = 1'b0;
    check("t6b_done", {39'd0, eventDone}, 40'd1);
    check("t6b_evcnt", {24'd0, eventCount}, 40'd0);

    // enable=0 aborts the event silently
    do_reset();
    send(2'b01, hdr(8'd1), 1'b0);
    send(2'b10, dat(0), 1'b0);
    enable    = 1'b0;
    dataValid = 1'b1;
    dataType  = 2'b10;
    din       = dat(1);
    idle_cycle();
    dataValid = 1'b0;
    dataType  = 2'b00;
    enable    = 1'b1;
    check("t7_wren_off", {39'd0, doutWrEn}, 40'd0);
    check("t7_done_off", {39'd0, eventDone}, 40'd0);
    send(2'b11, trl(8'd1), 1'b0);
    check("t7_nodone", {39'd0, eventDone}, 40'd0);
    check("t7_err", {37'd0, errorCode}, 40'd1);
    check("t7_evcnt", {24'd0, eventCount}, 40'd0);

    // MAX_HITS boundary: 208 data frames good, 209 is an error
    do_reset();
    send(2'b01, hdr(8'd1), 1'b0);
    for (int i = 0; i < 208; i++) send(2'b10, dat(i), 1'b0);
    send(2'b11, trl(8'd208), 1'b0);
    check("t8_max_done", {39'd0, eventDone}, 40'd1);
    check("t8_max_good", {39'd0, eventGood}, 40'd1);
    check("t8_max_err", {37'd0, errorCode}, 40'd0);
    send(2'b01, hdr(8'd2), 1'b0);
    for (int i = 0; i < 209; i++) send(2'b10, dat(i), 1'b0);
    send(2'b11, trl(8'd209), 1'b0);
    check("t8_over_done", {39'd0, eventDone}, 40'd1);
    check("t8_over_good", {39'd0, eventGood}, 40'd0);
    idle_cycle();
    check("t8_over_err", {37'd0, errorCode}, 40'd5);
    check("t8_evcnt", {24'd0, eventCount}, 40'd2);
    check("t8_badcnt", {24'd0, badEventCount}, 40'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
